// File: rtl/unidade_controle_rodadas_pkg.sv
// Shared definitions for the round-based memory game control unit: state encodings,
// timer default and the Moore output decode.
package unidade_controle_rodadas_pkg;

  localparam int unsigned TimeoutCyclesDefault = 5000;

  // Raw encodings, also consumed by the 7-segment debug decoder.
  localparam logic [3:0] EstInicial      = 4'h0;
  localparam logic [3:0] EstInicializa   = 4'h1;
  localparam logic [3:0] EstInicioRodada = 4'h2;
  localparam logic [3:0] EstEspera       = 4'h4;
  localparam logic [3:0] EstRegistra     = 4'h5;
  localparam logic [3:0] EstCompara      = 4'h6;
  localparam logic [3:0] EstProxima      = 4'h7;
  localparam logic [3:0] EstFimRodada    = 4'h8;
  localparam logic [3:0] EstEsgotado     = 4'hD;
  localparam logic [3:0] EstErro         = 4'hE;
  localparam logic [3:0] EstAcerto       = 4'hF;

  typedef enum logic [3:0] {
    StInicial      = EstInicial,
    StInicializa   = EstInicializa,
    StInicioRodada = EstInicioRodada,
    StEspera       = EstEspera,
    StRegistra     = EstRegistra,
    StCompara      = EstCompara,
    StProxima      = EstProxima,
    StFimRodada    = EstFimRodada,
    StEsgotado     = EstEsgotado,
    StErro         = EstErro,
    StAcerto       = EstAcerto
  } estado_e;

  typedef struct packed {
    logic zera_e;
    logic conta_e;
    logic zera_r;
    logic conta_r;
    logic zera_reg;
    logic registra_r;
    logic acertou;
    logic errou;
    logic timeout;
    logic pronto;
  } saidas_t;

  function automatic saidas_t decodifica_saidas(input estado_e est);
    saidas_t s;
    s = '0;
    case (est)
      StInicial, StInicializa: begin
        s.zera_e   = 1'b1;
        s.zera_r   = 1'b1;
        s.zera_reg = 1'b1;
      end
      StInicioRodada: s.zera_e     = 1'b1;
      StProxima:      s.conta_e    = 1'b1;
      StFimRodada:    s.conta_r    = 1'b1;
      StRegistra:     s.registra_r = 1'b1;
      StAcerto: begin
        s.acertou = 1'b1;
        s.pronto  = 1'b1;
      end
      StErro: begin
        s.errou  = 1'b1;
        s.pronto = 1'b1;
      end
      StEsgotado: begin
        s.errou   = 1'b1;
        s.timeout = 1'b1;
        s.pronto  = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/unidade_controle_rodadas_contador_timeout.sv
// Per-play timeout counter: cleared by zera_i, counts while conta_i, flags count == M-1.
module contador_timeout #(
  parameter int unsigned M = 5000
) (
  input  logic clock_i,
  input  logic reset_ni,
  input  logic zera_i,
  input  logic conta_i,
  output logic fim_o
);

  localparam int unsigned Width = $clog2(M + 1);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (zera_i) begin
      cnt_d = '0;
    end else if (conta_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fim_o = (cnt_q == Width'(M - 1));

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Moore control unit for the multi-round memory game: sequences the play/round counters,
// play register and comparator, with a built-in per-play timeout.
module unidade_controle_rodadas
  import unidade_controle_rodadas_pkg::*;
#(
  parameter int unsigned TimeoutCycles = TimeoutCyclesDefault
) (
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic       iniciar_i,
  input  logic       jogada_i,
  input  logic       igual_i,
  input  logic       fim_e_i,
  input  logic       fim_r_i,
  output logic       zera_e_o,
  output logic       conta_e_o,
  output logic       zera_r_o,
  output logic       conta_r_o,
  output logic       zera_reg_o,
  output logic       registra_r_o,
  output logic       acertou_o,
  output logic       errou_o,
  output logic       timeout_o,
  output logic       pronto_o,
  output logic [3:0] db_estado_o
);

  estado_e estado_q, estado_d;
  saidas_t saidas_q;
  logic    zera_timer, conta_timer, fim_timer, expirou;

  // Timer only runs in espera, so every entry into espera starts from zero.
  assign conta_timer = (estado_q == StEspera);
  assign zera_timer  = ~conta_timer;
  assign expirou     = conta_timer & fim_timer;

  contador_timeout #(
    .M(TimeoutCycles)
  ) u_timer (
    .clock_i (clock_i),
    .reset_ni(reset_ni),
    .zera_i  (zera_timer),
    .conta_i (conta_timer),
    .fim_o   (fim_timer)
  );

  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      StInicial:      if (iniciar_i) estado_d = StInicializa;
      StInicializa:   estado_d = StInicioRodada;
      StInicioRodada: estado_d = StEspera;
      StEspera: begin
        if (jogada_i) begin
          estado_d = StRegistra;
        end else if (expirou) begin
          estado_d = StEsgotado;
        end
      end
      StRegistra:     estado_d = StCompara;
      StCompara: begin
        if (!igual_i) begin
          estado_d = StErro;
        end else if (!fim_e_i) begin
          estado_d = StProxima;
        end else if (!fim_r_i) begin
          estado_d = StFimRodada;
        end else begin
          estado_d = StAcerto;
        end
      end
      StProxima:      estado_d = StEspera;
      StFimRodada:    estado_d = StInicioRodada;
      StAcerto, StErro, StEsgotado: if (iniciar_i) estado_d = StInicializa;
      default:        estado_d = StInicial;
    endcase
  end

  // Outputs are registered from the next state so they always match the state register.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      estado_q <= StInicial;
      saidas_q <= decodifica_saidas(StInicial);
    end else begin
      estado_q <= estado_d;
      saidas_q <= decodifica_saidas(estado_d);
    end
  end

  assign zera_e_o     = saidas_q.zera_e;
  assign conta_e_o    = saidas_q.conta_e;
  assign zera_r_o     = saidas_q.zera_r;
  assign conta_r_o    = saidas_q.conta_r;
  assign zera_reg_o   = saidas_q.zera_reg;
  assign registra_r_o = saidas_q.registra_r;
  assign acertou_o    = saidas_q.acertou;
  assign errou_o      = saidas_q.errou;
  assign timeout_o    = saidas_q.timeout;
  assign pronto_o     = saidas_q.pronto;
  assign db_estado_o  = estado_q;

endmodule

// File: tb/tb_unidade_controle_rodadas.sv
// Game-level randomized bench: stimulus tasks push the expected state per cycle, a negedge
// monitor pops and compares state and outputs.
module tb_unidade_controle_rodadas;

  localparam int unsigned T = 8;

  localparam logic [3:0] EIni = 4'h0, EInz = 4'h1, ERod = 4'h2, EEsp = 4'h4, EReg = 4'h5;
  localparam logic [3:0] ECmp = 4'h6, EProx = 4'h7, EFimR = 4'h8, EEsg = 4'hD, EErr = 4'hE;
  localparam logic [3:0] EAce = 4'hF;

  logic       clk, rst_n, iniciar, jogada, igual, fim_e, fim_r;
  logic       zera_e, conta_e, zera_r, conta_r, zera_reg, registra_r;
  logic       acertou, errou, timeout, pronto;
  logic [3:0] db_estado;
  logic [9:0] outs;

  int         checks = 0;
  int         failures = 0;
  int         ce_cnt = 0;
  int         cr_cnt = 0;
  logic [3:0] exp_q[$];

  unidade_controle_rodadas #(
    .TimeoutCycles(T)
  ) dut (
    .clock_i     (clk),
    .reset_ni    (rst_n),
    .iniciar_i   (iniciar),
    .jogada_i    (jogada),
    .igual_i     (igual),
    .fim_e_i     (fim_e),
    .fim_r_i     (fim_r),
    .zera_e_o    (zera_e),
    .conta_e_o   (conta_e),
    .zera_r_o    (zera_r),
    .conta_r_o   (conta_r),
    .zera_reg_o  (zera_reg),
    .registra_r_o(registra_r),
    .acertou_o   (acertou),
    .errou_o     (errou),
    .timeout_o   (timeout),
    .pronto_o    (pronto),
    .db_estado_o (db_estado)
  );

  assign outs = {zera_e, conta_e, zera_r, conta_r, zera_reg, registra_r,
                 acertou, errou, timeout, pronto};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Output values each game state must show, straight from the output table.
  function automatic logic [9:0] exp_out(input logic [3:0] s);
    return {s inside {EIni, EInz, ERod}, s == EProx, s inside {EIni, EInz}, s == EFimR,
            s inside {EIni, EInz}, s == EReg, s == EAce, s inside {EErr, EEsg}, s == EEsg,
            s inside {EAce, EErr, EEsg}};
  endfunction

  always @(negedge clk) begin
    logic [3:0] exp_s;
    if (rst_n) begin
      ce_cnt += int'(conta_e);
      cr_cnt += int'(conta_r);
    end
    if (exp_q.size() > 0) begin
      exp_s = exp_q.pop_front();
      checks++;
      if (db_estado !== exp_s || outs !== exp_out(exp_s)) begin
        failures++;
        $display("FAIL state_outputs t=%0t: got estado=%h saidas=%b, expected estado=%h saidas=%b",
                 $time, db_estado, outs, exp_s, exp_out(exp_s));
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic tick(input logic [3:0] s);
    exp_q.push_back(s);
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    igual = 1'($urandom);
    fim_e = 1'($urandom);
    fim_r = 1'($urandom);
  endtask

  // One play starting in espera; returns the state reached after compara's aftermath.
  task automatic do_play(input bit ok, input bit fe, input bit fr, input int dly,
                         output logic [3:0] nxt);
    iniciar = 1'b0;
    jogada  = 1'b0;
    for (int i = 0; i < dly; i++) begin
      scramble();
      tick(EEsp);
    end
    jogada = 1'b1;
    igual  = ok;
    fim_e  = fe;
    fim_r  = fr;
    tick(EEsp);
    jogada  = 1'($urandom);
    iniciar = 1'($urandom);
    tick(EReg);
    tick(ECmp);
    scramble();
    if (!ok) begin
      nxt = EErr;
    end else if (!fe) begin
      tick(EProx);
      nxt = EEsp;
    end else if (!fr) begin
      tick(EFimR);
      tick(ERod);
      nxt = EEsp;
    end else begin
      nxt = EAce;
    end
    jogada  = 1'b0;
    iniciar = 1'b0;
  endtask

  task automatic do_timeout();
    iniciar = 1'b0;
    jogada  = 1'b0;
    repeat (T) begin
      scramble();
      tick(EEsp);
    end
  endtask

  task automatic abort_in_compara();
    iniciar = 1'b0;
    jogada  = 1'b1;
    igual   = 1'b1;
    tick(EEsp);
    jogada = 1'b0;
    tick(EReg);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_estado", int'(db_estado), int'(EIni));
    check("async_reset_saidas", int'(outs), int'(exp_out(EIni)));
    @(posedge clk);
    #1;
    tick(EIni);
    rst_n = 1'b1;
    tick(EIni);
  endtask

  // Plays a game with a modelled datapath: round r needs plays 0..r, last round is `last`.
  task automatic run_game(input int last, input int fail_r, input int fail_e, input int to_r,
                          input int to_e, input int abort_r, output logic [3:0] res);
    int         r = 0, e = 0, exp_ce = 0, exp_cr = 0, dly;
    int         ce0 = ce_cnt, cr0 = cr_cnt;
    bit         ok, fe, fr;
    logic [3:0] nxt;
    res = EEsp;
    while (res == EEsp) begin
      if (r == to_r && e == to_e) begin
        do_timeout();
        res = EEsg;
      end else if (r == abort_r && e == 0) begin
        abort_in_compara();
        res = EIni;
      end else begin
        ok  = !(r == fail_r && e == fail_e);
        fe  = (e == r);
        fr  = (r == last);
        dly = ($urandom_range(0, 3) == 0) ? int'(T) - 1 : int'($urandom_range(0, 3));
        do_play(ok, fe, fr, dly, nxt);
        if (nxt == EEsp) begin
          if (!fe) begin
            e++;
            exp_ce++;
          end else begin
            r++;
            e = 0;
            exp_cr++;
          end
        end
        res = nxt;
      end
    end
    check("contaE_pulses", ce_cnt - ce0, exp_ce);
    check("contaR_pulses", cr_cnt - cr0, exp_cr);
  endtask

  // Lingers in a terminal state with noise on jogada, then restarts into espera.
  task automatic hold_and_restart(input logic [3:0] st);
    iniciar = 1'b0;
    repeat ($urandom_range(1, 3)) begin
      jogada = 1'($urandom);
      scramble();
      tick(st);
    end
    jogada  = 1'b0;
    iniciar = 1'b1;
    tick(st);
    iniciar = 1'b0;
    tick(EInz);
    tick(ERod);
  endtask

  initial begin
    logic [3:0] res;
    int         last, mode, fr_, fe_;
    rst_n   = 1'b0;
    iniciar = 1'b1;
    jogada  = 1'b0;
    igual   = 1'b0;
    fim_e   = 1'b0;
    fim_r   = 1'b0;
    @(posedge clk);
    #1;
    repeat (2) tick(EIni);
    rst_n = 1'b1;
    tick(EIni);
    iniciar = 1'b0;
    tick(EInz);
    tick(ERod);

    run_game(3, -1, -1, -1, -1, -1, res);
    check("full_game_result", int'(res), int'(EAce));
    hold_and_restart(res);

    run_game(1, 1, 1, -1, -1, -1, res);
    check("mismatch_result", int'(res), int'(EErr));
    hold_and_restart(res);

    run_game(3, -1, -1, 1, 1, -1, res);
    check("timeout_result", int'(res), int'(EEsg));
    hold_and_restart(res);

    run_game(3, -1, -1, -1, -1, 2, res);
    check("abort_result", int'(res), int'(EIni));
    hold_and_restart(res);

    for (int g = 0; g < 8; g++) begin
      last = int'($urandom_range(0, 3));
      mode = int'($urandom_range(0, 2));
      fr_  = int'($urandom_range(0, last));
      fe_  = int'($urandom_range(0, fr_));
      if (mode == 0) begin
        run_game(last, -1, -1, -1, -1, -1, res);
        check("rand_game_acerto", int'(res), int'(EAce));
      end else if (mode == 1) begin
        run_game(last, fr_, fe_, -1, -1, -1, res);
        check("rand_game_erro", int'(res), int'(EErr));
      end else begin
        run_game(last, -1, -1, fr_, fe_, -1, res);
        check("rand_game_esgotado", int'(res), int'(EEsg));
      end
      hold_and_restart(res);
    end

    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
